// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding, default
// operand width and the iteration-counter width helper.
package multiplicador_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2 n), never narrower than one bit so N=1 still has a counter.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/multiplicador_seq4_if.sv
// Request/result bundle of the multiplier: operands and start in, product
// with busy/done status out.
interface multiplicador_seq4_if #(
  parameter int N = multiplicador_pkg::N_DEFAULT
);
  logic             start;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic [2*N-1:0]   P;
  logic             busy;
  logic             done;

  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/somador_mult4.sv
// Combinational N-bit ripple adder with carry-in tied low; the single adder
// shared by every iteration of the multiplier.
module somador_mult4 #(
  parameter int N = multiplicador_pkg::N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[N];

endmodule

// File: rtl/multiplicador_seq4.sv
// Shift-and-add unsigned multiplier: N iterations through one shared adder,
// registered product, busy during iterations and a one-cycle done strobe.
module multiplicador_seq4
  import multiplicador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplicador_seq4_if.slave  bus
);

  localparam int CNT_W = cnt_width(N);

  state_t             state_reg, state_next;
  logic [N-1:0]       m_reg, m_next;
  logic [N-1:0]       q_reg, q_next;
  logic [N-1:0]       acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*N-1:0]     p_reg, p_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [N-1:0]       addend;
  logic [N-1:0]       sum;
  logic               cout;

  assign addend = q_reg[0] ? m_reg : '0;

  somador_mult4 #(.N(N)) u_somador (
    .a    (acc_reg),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE so results can stream back-to-back.
        if (bus.start) begin
          m_next     = bus.A;
          q_next     = bus.B;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        // The adder carry becomes the new ACC MSB; the old Q[0] falls off the end.
        {acc_next, q_next} = {cout, sum, q_reg[N-1:1]};
        cnt_next           = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(N - 1)) begin
          p_next     = {cout, sum, q_reg[N-1:1]};
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  assign bus.P    = p_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule
